// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and load extraction shared by the load/store unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

    function automatic logic [31:0] load_ext(logic [31:0] w, logic [2:0] f3, logic [1:0] lane);
        logic [31:0] s;
        s = w >> {lane, 3'b000};
        return f3[1] ? w :
               f3[0] ? {{16{s[15] & ~f3[2]}}, s[15:0]} :
                       {{24{s[7] & ~f3[2]}}, s[7:0]};
    endfunction
endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous word RAM with registered read data
module data_ram #(
    parameter int DEPTH = 128,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage performing byte/half/word loads and stores on an internal RAM
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          DATA_MEMORY_DEPTH = 128,
    parameter logic [31:0] DATA_BASE_ADDR    = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Read_i,
    input  logic        Mem_Write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        Stall_o,
    output logic        Done_o,
    output logic        Error_o
);
    localparam int AW = $clog2(DATA_MEMORY_DEPTH);

    state_t      state;
    logic [31:0] offset, old_word, rdata, mask, rep, wdata;
    logic [1:0]  lane;
    logic        req, bad_f3, misaligned, reject, we;

    // base is word aligned, so the offset's low bits are the byte lane
    assign offset     = Address_i - DATA_BASE_ADDR;
    assign lane       = offset[1:0];
    assign req        = Mem_Read_i ^ Mem_Write_i;
    assign bad_f3     = Mem_Read_i ? !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                                   : !(funct3_i inside {F3_B, F3_H, F3_W});
    assign misaligned = (funct3_i[1:0] == 2'b01 && lane[0]) || (funct3_i[1:0] == 2'b10 && lane != 2'b00);
    // addresses below the base wrap to huge offsets and fail the same bound
    assign reject     = (Mem_Read_i && Mem_Write_i) || bad_f3 || misaligned ||
                        offset >= 32'(4 * DATA_MEMORY_DEPTH);
    assign Stall_o    = reset && ((state == IDLE && req) || state == READ || state == WRITE);
    assign we         = reset && state == WRITE;

    always_comb begin
        mask  = funct3_i == F3_B ? 32'h0000_00FF << {lane, 3'b000} :
                funct3_i == F3_H ? 32'h0000_FFFF << {lane[1], 4'b0000} : '1;
        rep   = funct3_i == F3_B ? {4{Write_Data_i[7:0]}} :
                funct3_i == F3_H ? {2{Write_Data_i[15:0]}} : Write_Data_i;
        wdata = (old_word & ~mask) | (rep & mask);
    end

    data_ram #(.DEPTH(DATA_MEMORY_DEPTH)) u_ram (
        .clk(clk), .we(we), .addr(offset[AW+1:2]), .wdata(wdata), .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            Read_Data_o <= '0;
            Done_o      <= 1'b0;
            Error_o     <= 1'b0;
        end else begin
            Done_o  <= 1'b0;
            Error_o <= 1'b0;
            case (state)
                IDLE: if (Mem_Read_i || Mem_Write_i) begin
                    if (reject) begin
                        state   <= RESP;
                        Done_o  <= 1'b1;
                        Error_o <= 1'b1;
                        if (Mem_Read_i) Read_Data_o <= '0;
                    end else begin
                        state <= (Mem_Write_i && funct3_i == F3_W) ? WRITE : READ;
                    end
                end
                READ: if (Mem_Read_i) begin
                    Read_Data_o <= load_ext(rdata, funct3_i, lane);
                    state       <= RESP;
                    Done_o      <= 1'b1;
                end else begin
                    old_word <= rdata;
                    state    <= WRITE;
                end
                WRITE: begin
                    state  <= RESP;
                    Done_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors with hand-computed results, latencies and stalls
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 0, reset = 0, mr = 0, mw = 0;
    logic [2:0]  f3 = 0;
    logic [31:0] addr = 0, wd = 0;
    logic [31:0] rd_data;
    logic        stall, done, err;
    int          checks = 0, failures = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .Mem_Read_i(mr), .Mem_Write_i(mw), .funct3_i(f3),
        .Address_i(addr), .Write_Data_i(wd), .Read_Data_o(rd_data), .Stall_o(stall),
        .Done_o(done), .Error_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic op(string tag, logic r, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d,
                      int lat, int st, logic [31:0] rd_exp, logic err_exp, logic chk_rd);
        int n = 0, s = 0;
        logic seen = 0;
        @(negedge clk);
        mr = r; mw = w; f3 = f; addr = a; wd = d;
        #1 s += int'(stall);
        while (!seen && n < 8) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = done;
            s += int'(stall);
        end
        chk({tag, ".done"}, 32'(seen), 1);
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".stall"}, s, st);
        chk({tag, ".err"}, 32'(err), 32'(err_exp));
        if (chk_rd) chk({tag, ".data"}, rd_data, rd_exp);
        mr = 0; mw = 0;
        @(negedge clk);
        chk({tag, ".once"}, 32'(done), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.data", rd_data, 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.stall", 32'(stall), 0);
        reset = 1;

        op("sw0", 0, 1, F3_W, 32'h1001_0004, 32'hDEAD_BEEF, 2, 2, 0, 0, 0);
        op("lw0", 1, 0, F3_W, 32'h1001_0004, 0, 2, 2, 32'hDEAD_BEEF, 0, 1);
        op("lb7", 1, 0, F3_B, 32'h1001_0007, 0, 2, 2, 32'hFFFF_FFDE, 0, 1);
        op("lbu7", 1, 0, F3_BU, 32'h1001_0007, 0, 2, 2, 32'h0000_00DE, 0, 1);
        op("lh4", 1, 0, F3_H, 32'h1001_0004, 0, 2, 2, 32'hFFFF_BEEF, 0, 1);
        op("lhu4", 1, 0, F3_HU, 32'h1001_0004, 0, 2, 2, 32'h0000_BEEF, 0, 1);
        op("sh6", 0, 1, F3_H, 32'h1001_0006, 32'h0000_1234, 3, 3, 0, 0, 0);
        op("lw1", 1, 0, F3_W, 32'h1001_0004, 0, 2, 2, 32'h1234_BEEF, 0, 1);
        op("lb5", 1, 0, F3_B, 32'h1001_0005, 0, 2, 2, 32'hFFFF_FFBE, 0, 1);
        op("sb4", 0, 1, F3_B, 32'h1001_0004, 32'hFFFF_FF55, 3, 3, 0, 0, 0);
        op("lw2", 1, 0, F3_W, 32'h1001_0004, 0, 2, 2, 32'h1234_BE55, 0, 1);

        op("lwmis", 1, 0, F3_W, 32'h1001_0002, 0, 1, 1, 0, 1, 1);
        op("lwoor", 1, 0, F3_W, 32'h1001_0200, 0, 1, 1, 0, 1, 1);
        op("lwlow", 1, 0, F3_W, 32'h1000_FFFC, 0, 1, 1, 0, 1, 1);
        op("both", 1, 1, F3_W, 32'h1001_0004, 32'hFFFF_FFFF, 1, 0, 0, 1, 1);
        op("lwf3", 1, 0, 3'b011, 32'h1001_0004, 0, 1, 1, 0, 1, 1);
        op("shmis", 0, 1, F3_H, 32'h1001_0005, 32'hFFFF_FFFF, 1, 1, 0, 1, 0);
        op("sbf3", 0, 1, F3_BU, 32'h1001_0004, 32'hFFFF_FFFF, 1, 1, 0, 1, 0);
        op("lw3", 1, 0, F3_W, 32'h1001_0004, 0, 2, 2, 32'h1234_BE55, 0, 1);

        op("swtop", 0, 1, F3_W, 32'h1001_01FC, 32'h0BAD_F00D, 2, 2, 0, 0, 0);
        op("lwtop", 1, 0, F3_W, 32'h1001_01FC, 0, 2, 2, 32'h0BAD_F00D, 0, 1);
        op("lhutop", 1, 0, F3_HU, 32'h1001_01FE, 0, 2, 2, 32'h0000_0BAD, 0, 1);

        op("sw00", 0, 1, F3_W, 32'h1001_0000, 32'h1122_3344, 2, 2, 0, 0, 0);
        @(negedge clk);
        mw = 1; f3 = F3_B; addr = 32'h1001_0000; wd = 32'h0000_00AA;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rstw.stall", 32'(stall), 0);
        chk("rstw.done", 32'(done), 0);
        chk("rstw.data", rd_data, 0);
        mw = 0;
        reset = 1;
        op("lw00", 1, 0, F3_W, 32'h1001_0000, 0, 2, 2, 32'h1122_3344, 0, 1);

        op("b2b.lw", 1, 0, F3_W, 32'h1001_0004, 0, 2, 2, 32'h1234_BE55, 0, 1);
        op("b2b.sw", 0, 1, F3_W, 32'h1001_0008, 32'hCAFE_F00D, 2, 2, 0, 0, 0);
        op("b2b.lw2", 1, 0, F3_W, 32'h1001_0008, 0, 2, 2, 32'hCAFE_F00D, 0, 1);
        op("b2b.lw3", 1, 0, F3_W, 32'h1001_0004, 0, 2, 2, 32'h1234_BE55, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
